// File: rtl/d8m_sensor_pattern_tx.sv
// Purpose: D8M sensor-side transmitter generating a GRBG Bayer test pattern with FVAL/LVAL framing.
// Latency: all outputs registered; fval rises on the same edge that samples enable high in IDLE.
// Backpressure: none, free-running source at one pixel per clock. Line CRC gated by D8M_TX_LINE_CRC_EN.
module d8m_sensor_pattern_tx #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 160,
    parameter int FV_SETUP = 4,
    parameter int V_BLANK  = 1000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] const_value,
    output logic [11:0] cam_d,
    output logic        cam_fval,
    output logic        cam_lval,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic [15:0] line_crc,
    output logic        line_crc_valid
);

    // Width of one colour bar; H_ACTIVE is a multiple of 8 so this is exact.
    localparam int BAR_W = H_ACTIVE / 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FSETUP = 3'd1,
        S_ACTIVE = 3'd2,
        S_HBLANK = 3'd3,
        S_VBLANK = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;          // cycles spent in FSETUP/HBLANK/VBLANK
    logic [15:0] x_q, x_d;              // active pixel index within the line
    logic [15:0] y_q, y_d;              // active line index within the frame
    logic [2:0]  bar_q, bar_d;          // colour bar index, advanced without a divider
    logic [15:0] bar_px_q, bar_px_d;    // pixel position inside the current bar
    logic        latch_cfg;             // frame start: capture pattern selection

    logic [1:0]  pat_q;
    logic [11:0] const_q;
    logic [11:0] d_q, pix_d;
    logic        fval_q, fval_d;
    logic        lval_q, lval_d;
    logic        done_q, done_d;
    logic [15:0] fcount_q, fcount_d;

    logic [2:0]  rgb;                   // {r,g,b} of the current bar
    logic        site_on;               // selected channel at this Bayer site

    // State register and frame geometry counters.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 32'd0;
            x_q      <= 16'd0;
            y_q      <= 16'd0;
            bar_q    <= 3'd0;
            bar_px_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            bar_q    <= bar_d;
            bar_px_q <= bar_px_d;
        end
    end

    // Next-state logic: walks setup, active lines, horizontal and vertical blanking.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        bar_d     = bar_q;
        bar_px_d  = bar_px_q;
        latch_cfg = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d   = S_FSETUP;
                    cnt_d     = 32'd0;
                    latch_cfg = 1'b1;
                end
            end
            S_FSETUP: begin
                if (cnt_q == 32'(FV_SETUP - 1)) begin
                    state_d  = S_ACTIVE;
                    cnt_d    = 32'd0;
                    x_d      = 16'd0;
                    y_d      = 16'd0;
                    bar_d    = 3'd0;
                    bar_px_d = 16'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_ACTIVE: begin
                if (x_q == 16'(H_ACTIVE - 1)) begin
                    cnt_d = 32'd0;
                    // Last line ends the frame: fval drops together with lval.
                    if (y_q == 16'(V_ACTIVE - 1)) begin
                        state_d = S_VBLANK;
                    end else begin
                        state_d = S_HBLANK;
                    end
                end else begin
                    x_d = x_q + 16'd1;
                    if (bar_px_q == 16'(BAR_W - 1)) begin
                        bar_px_d = 16'd0;
                        bar_d    = bar_q + 3'd1;
                    end else begin
                        bar_px_d = bar_px_q + 16'd1;
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q == 32'(H_BLANK - 1)) begin
                    state_d  = S_ACTIVE;
                    cnt_d    = 32'd0;
                    x_d      = 16'd0;
                    y_d      = y_q + 16'd1;
                    bar_d    = 3'd0;
                    bar_px_d = 16'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_VBLANK: begin
                // enable is only looked at here, so a started frame always completes.
                if (cnt_q == 32'(V_BLANK - 1)) begin
                    cnt_d = 32'd0;
                    if (enable) begin
                        state_d   = S_FSETUP;
                        latch_cfg = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    // Pixel and framing values for the state being entered, registered below.
    always_comb begin
        rgb     = 3'b000;
        site_on = 1'b0;
        pix_d   = 12'h000;
        fval_d  = (state_d == S_FSETUP) || (state_d == S_ACTIVE) || (state_d == S_HBLANK);
        lval_d  = (state_d == S_ACTIVE);
        done_d  = (state_q == S_ACTIVE) && (state_d == S_VBLANK);
        fcount_d = fcount_q + {15'd0, done_d};
        unique case (bar_d)
            3'd0:    rgb = 3'b111;  // white
            3'd1:    rgb = 3'b110;  // yellow
            3'd2:    rgb = 3'b011;  // cyan
            3'd3:    rgb = 3'b010;  // green
            3'd4:    rgb = 3'b101;  // magenta
            3'd5:    rgb = 3'b100;  // red
            3'd6:    rgb = 3'b001;  // blue
            default: rgb = 3'b000;  // black
        endcase
        // GRBG mosaic: even line G R G R, odd line B G B G.
        unique case ({y_d[0], x_d[0]})
            2'b00:   site_on = rgb[1];
            2'b01:   site_on = rgb[2];
            2'b10:   site_on = rgb[0];
            default: site_on = rgb[1];
        endcase
        if (lval_d) begin
            unique case (pat_q)
                2'd0:    pix_d = x_d[11:0] + y_d[11:0];
                2'd1:    pix_d = {12{site_on}};
                2'd2:    pix_d = const_q;
                default: pix_d = {fcount_q[3:0], x_d[7:0]};
            endcase
        end
    end

    // Output registers, frame counter and per-frame pattern configuration.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            d_q      <= 12'h000;
            fval_q   <= 1'b0;
            lval_q   <= 1'b0;
            done_q   <= 1'b0;
            fcount_q <= 16'd0;
            pat_q    <= 2'd0;
            const_q  <= 12'h000;
        end else begin
            d_q      <= pix_d;
            fval_q   <= fval_d;
            lval_q   <= lval_d;
            done_q   <= done_d;
            fcount_q <= fcount_d;
            if (latch_cfg) begin
                pat_q   <= pattern_sel;
                const_q <= const_value;
            end
        end
    end

    assign cam_d       = d_q;
    assign cam_fval    = fval_q;
    assign cam_lval    = lval_q;
    assign frame_done  = done_q;
    assign frame_count = fcount_q;

`ifdef D8M_TX_LINE_CRC_EN
    logic [15:0] crc_acc_q;
    logic [15:0] line_crc_q;
    logic        lval_prev_q;
    logic        crc_vld_q;

    // CRC-16-CCITT advanced by 12 data bits, MSB first.
    function automatic logic [15:0] crc12(input logic [15:0] crc_in, input logic [11:0] dat);
        logic [15:0] c;
        c = crc_in;
        for (int i = 11; i >= 0; i--) begin
            if (c[15] ^ dat[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Accumulate over the pixels on the wire; publish one cycle after lval falls.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            crc_acc_q   <= 16'hFFFF;
            line_crc_q  <= 16'h0000;
            lval_prev_q <= 1'b0;
            crc_vld_q   <= 1'b0;
        end else begin
            lval_prev_q <= lval_q;
            crc_vld_q   <= lval_prev_q & ~lval_q;
            if (lval_q) begin
                crc_acc_q <= crc12(lval_prev_q ? crc_acc_q : 16'hFFFF, d_q);
            end
            if (lval_prev_q & ~lval_q) begin
                line_crc_q <= crc_acc_q;
            end
        end
    end

    assign line_crc       = line_crc_q;
    assign line_crc_valid = crc_vld_q;
`else
    assign line_crc       = 16'h0000;
    assign line_crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_d8m_sensor_pattern_tx.sv
// Purpose: scoreboard bench for d8m_sensor_pattern_tx with small frame geometry.
// Latency: expected pixels/frame counts/line CRCs are queued at frame start and popped by a monitor.
// Backpressure: none; the monitor samples on the falling clock edge.
`timescale 1ns/1ps
module tb_d8m_sensor_pattern_tx;

    localparam int H_ACTIVE = 16;
    localparam int V_ACTIVE = 4;
    localparam int H_BLANK  = 4;
    localparam int FV_SETUP = 2;
    localparam int V_BLANK  = 8;
    localparam int FV_LEN   = FV_SETUP + V_ACTIVE * H_ACTIVE + (V_ACTIVE - 1) * H_BLANK; // 78
    localparam int PERIOD   = FV_LEN + V_BLANK;                                          // 86

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [11:0] const_value;
    logic [11:0] cam_d;
    logic        cam_fval;
    logic        cam_lval;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [15:0] line_crc;
    logic        line_crc_valid;

    always #5 clk_clk = ~clk_clk;

    d8m_sensor_pattern_tx #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
        .FV_SETUP(FV_SETUP), .V_BLANK(V_BLANK)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .enable         (enable),
        .pattern_sel    (pattern_sel),
        .const_value    (const_value),
        .cam_d          (cam_d),
        .cam_fval       (cam_fval),
        .cam_lval       (cam_lval),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .line_crc       (line_crc),
        .line_crc_valid (line_crc_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_pix[$];
    logic [15:0] exp_fc[$];
    logic [15:0] exp_crc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference pixel for pattern/frame/position.
    function automatic logic [11:0] exp_pixel(input int pat, input logic [11:0] cv,
                                              input logic [15:0] fc, input int x, input int y);
        logic [2:0] rgb;
        logic       on;
        rgb = 3'b000;
        on  = 1'b0;
        case (pat)
            0: return 12'((x + y) % 4096);
            1: begin
                case (x / (H_ACTIVE / 8))
                    0: rgb = 3'b111;
                    1: rgb = 3'b110;
                    2: rgb = 3'b011;
                    3: rgb = 3'b010;
                    4: rgb = 3'b101;
                    5: rgb = 3'b100;
                    6: rgb = 3'b001;
                    default: rgb = 3'b000;
                endcase
                if (y % 2 == 0) on = (x % 2 == 0) ? rgb[1] : rgb[2];
                else            on = (x % 2 == 0) ? rgb[0] : rgb[1];
                return on ? 12'hFFF : 12'h000;
            end
            2: return cv;
            default: return {fc[3:0], 8'(x)};
        endcase
    endfunction

    // Queue everything one frame is expected to produce.
    task automatic push_frame(input int pat, input logic [11:0] cv, input logic [15:0] fc);
        logic [11:0] p;
        logic [15:0] crc;
        for (int y = 0; y < V_ACTIVE; y++) begin
            crc = 16'hFFFF;
            for (int x = 0; x < H_ACTIVE; x++) begin
                p = exp_pixel(pat, cv, fc, x, y);
                exp_pix.push_back(p);
                for (int b = 11; b >= 0; b--) begin
                    crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ p[b]) ? 16'h1021 : 16'h0000);
                end
            end
`ifdef D8M_TX_LINE_CRC_EN
            exp_crc.push_back(crc);
`endif
        end
        exp_fc.push_back(fc + 16'd1);
    endtask

    // Returns at the falling edge where fval is first seen high after being low.
    task automatic wait_fval_rise(input string name);
        int n;
        n = 0;
        while (cam_fval && n < 400) begin @(negedge clk_clk); n++; end
        while (!cam_fval && n < 400) begin @(negedge clk_clk); n++; end
        check(name, 32'(n < 400), 32'd1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pixel, frame end or line CRC.
    logic lval_h1 = 1'b0;
    logic lval_h2 = 1'b0;
    logic fd_h1   = 1'b0;
    int   quiet   = 3;
    always @(negedge clk_clk) begin
        if (!reset_reset_n) quiet = 3;
        else if (quiet > 0) quiet--;
        if (cam_lval) begin
            if (exp_pix.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL pixel: got 0x%0h, expected no pixel (t=%0t)", cam_d, $time);
            end else begin
                check("pixel", 32'(cam_d), 32'(exp_pix.pop_front()));
            end
            check("lval_within_fval", 32'(cam_fval), 32'd1);
        end else begin
            check("blank_d_zero", 32'(cam_d), 32'd0);
        end
        if (frame_done) begin
            if (exp_fc.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL frame_done: got pulse, expected none (t=%0t)", $time);
            end else begin
                check("frame_count", 32'(frame_count), 32'(exp_fc.pop_front()));
            end
            check("done_in_vblank", 32'({cam_fval, cam_lval}), 32'd0);
            check("done_one_cycle", 32'(fd_h1), 32'd0);
        end
`ifdef D8M_TX_LINE_CRC_EN
        if (quiet == 0) check("crc_valid_timing", 32'(line_crc_valid), 32'(lval_h2 & ~lval_h1));
        if (line_crc_valid) begin
            if (exp_crc.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL line_crc: got strobe 0x%0h, expected none (t=%0t)", line_crc, $time);
            end else begin
                check("line_crc", 32'(line_crc), 32'(exp_crc.pop_front()));
            end
        end
`else
        check("crc_disabled", 32'({line_crc, line_crc_valid}), 32'd0);
`endif
        lval_h2 = lval_h1;
        lval_h1 = cam_lval;
        fd_h1   = frame_done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_reset_n = 1'b0;
        enable        = 1'b0;
        pattern_sel   = 2'd0;
        const_value   = 12'h000;
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        check("rst_fval", 32'(cam_fval), 32'd0);
        check("rst_lval", 32'(cam_lval), 32'd0);
        check("rst_d", 32'(cam_d), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);
        reset_reset_n = 1'b1;
        repeat (3) @(negedge clk_clk);
        check("idle_fval", 32'(cam_fval), 32'd0);

        // Frame 0: ramp, with a cycle-by-cycle framing check.
        enable = 1'b1;
        @(negedge clk_clk);
        push_frame(0, 12'h000, 16'd0);
        for (int k = 0; k < PERIOD; k++) begin
            if (k > 0) @(negedge clk_clk);
            check("t_fval", 32'(cam_fval), 32'(k < FV_LEN));
            check("t_lval", 32'(cam_lval),
                  32'(k >= FV_SETUP && k < FV_LEN && ((k - FV_SETUP) % (H_ACTIVE + H_BLANK)) < H_ACTIVE));
            check("t_done", 32'(frame_done), 32'(k == FV_LEN));
            if (k == 10) pattern_sel = 2'd1;
        end
        @(negedge clk_clk);
        check("period_fval_rise", 32'(cam_fval), 32'd1);
        check("fc_after_f0", 32'(frame_count), 32'd1);

        // Frame 1: colour bars.
        push_frame(1, 12'h000, 16'd1);
        pattern_sel = 2'd2;
        const_value = 12'hA5A;

        // Frame 2: constant, changed mid-frame; frame 3 picks the new value.
        wait_fval_rise("start_f2");
        push_frame(2, 12'hA5A, 16'd2);
        repeat (30) @(negedge clk_clk);
        const_value = 12'h123;
        wait_fval_rise("start_f3");
        push_frame(2, 12'h123, 16'd3);
        pattern_sel = 2'd3;

        // Frame 4: frame-tagged ramp; enable dropped during line 2.
        wait_fval_rise("start_f4");
        push_frame(3, 12'h000, 16'd4);
        repeat (45) @(negedge clk_clk);
        enable = 1'b0;
        n = 0;
        while (cam_fval && n < 200) begin @(negedge clk_clk); n++; end
        check("drop_fval_fall_cycle", 32'(n), 32'(FV_LEN - 45));
        check("drop_all_pixels_sent", 32'(exp_pix.size()), 32'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_clk);
            check("idle_after_drop", 32'({cam_fval, cam_lval}), 32'd0);
        end
        check("fc_idle", 32'(frame_count), 32'd5);

        // Re-enable: fresh frame from x=y=0, then reset during line 1.
        pattern_sel = 2'd0;
        enable      = 1'b1;
        @(negedge clk_clk);
        check("reenable_fval", 32'(cam_fval), 32'd1);
        push_frame(0, 12'h000, 16'd5);
        repeat (30) @(negedge clk_clk);
        @(posedge clk_clk);
        #1 reset_reset_n = 1'b0;
        @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        exp_pix.delete();
        exp_fc.delete();
        exp_crc.delete();
        pattern_sel = 2'd2;
        const_value = 12'h000;
        @(negedge clk_clk);
        check("midrst_fval", 32'(cam_fval), 32'd0);
        check("midrst_lval", 32'(cam_lval), 32'd0);
        check("midrst_d", 32'(cam_d), 32'd0);
        check("midrst_fc", 32'(frame_count), 32'd0);
        @(negedge clk_clk);
        check("post_rst_fsetup", 32'(cam_fval), 32'd1);

        // Zero-constant frame for the line CRC, then stop.
        push_frame(2, 12'h000, 16'd0);
        enable = 1'b0;
        n = 0;
        while (cam_fval && n < 200) begin @(negedge clk_clk); n++; end
        check("last_fval_fall_cycle", 32'(n), 32'(FV_LEN));
        repeat (12) @(negedge clk_clk);
        check("final_idle", 32'({cam_fval, cam_lval}), 32'd0);
        check("final_pix_drained", 32'(exp_pix.size()), 32'd0);
        check("final_fc_drained", 32'(exp_fc.size()), 32'd0);
        check("final_fc", 32'(frame_count), 32'd1);
`ifdef D8M_TX_LINE_CRC_EN
        check("final_crc_drained", 32'(exp_crc.size()), 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/d8m_sensor_pattern_tx.md
Name: d8m_sensor_pattern_tx

Overview:
Sensor-side transmitter for the D8M parallel camera interface. It drives D[11:0], FVAL and LVAL exactly as the camera receiver expects, so the capture/VIP pipeline can be exercised without the physical sensor. Output is a raw Bayer (GRBG) test pattern at one pixel per clock, with programmable geometry and blanking. It sits in the top level behind a mux on the camera conduit, clocked by the same clock the receiver uses as PIXCLK.

Parameters:
H_ACTIVE, 640, active pixels per line; must be a multiple of 8 and >= 8
V_ACTIVE, 480, active lines per frame; >= 1
H_BLANK, 160, LVAL-low cycles between lines inside a frame; >= 1
FV_SETUP, 4, cycles with FVAL high before the first LVAL of a frame; >= 1
V_BLANK, 1000, cycles with FVAL and LVAL both low between frames; >= 1

Ports:
clk_clk  in  1  pixel clock; all logic on the rising edge
reset_reset_n  in  1  synchronous, active-low reset
enable  in  1  level; start frames and keep streaming while high
pattern_sel  in  2  0 ramp, 1 colour bars, 2 constant, 3 frame-tagged ramp
const_value  in  12  pixel value for pattern 2
cam_d  out  12  pixel data
cam_fval  out  1  frame valid
cam_lval  out  1  line valid
frame_done  out  1  one-cycle pulse at end of each frame
frame_count  out  16  completed-frame counter
line_crc  out  16  CRC of the last line (optional feature)
line_crc_valid  out  1  one-cycle strobe for line_crc (optional feature)

Behaviour:
- All outputs are registered. Reset forces every output, every counter and the FSM to 0/IDLE on the next edge, including mid-frame. Streaming then restarts from a fresh frame.
- FSM states: IDLE, FSETUP, ACTIVE, HBLANK, VBLANK.
- IDLE: fval=lval=0, cam_d=0. If enable is sampled 1 at edge N, go to FSETUP; cam_fval=1 from edge N. pattern_sel and const_value are latched at this edge and held for the whole frame.
- FSETUP: FV_SETUP cycles, fval=1, lval=0, then ACTIVE.
- ACTIVE: H_ACTIVE cycles, fval=lval=1, x counts 0..H_ACTIVE-1.
  - If y < V_ACTIVE-1, go to HBLANK.
  - Otherwise go to VBLANK; fval and lval fall on the same edge.
- HBLANK: H_BLANK cycles, fval=1, lval=0, then ACTIVE with y+1 and x=0.
- VBLANK: V_BLANK cycles, both low.
  - frame_done=1 during the first VBLANK cycle only.
  - frame_count increments on that same edge and wraps 0xFFFF->0x0000.
  - At the end of VBLANK: if enable=1, go to FSETUP and relatch the pattern; otherwise go to IDLE.
- Deasserting enable mid-frame never truncates a frame; the frame completes and the FSM then stops after VBLANK.
- Frame period = FV_SETUP + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_BLANK.
- cam_d is 0 whenever lval=0.
- Patterns (x, y are the active pixel/line indices):
  - 0: (x + y) mod 4096.
  - 1: 8 vertical bars, each H_ACTIVE/8 wide, tracked by a bar counter (no divider). Bars in order: white, yellow, cyan, green, magenta, red, blue, black. Each channel value is 0xFFF or 0x000. Bayer site: y even/x even=G, y even/x odd=R, y odd/x even=B, y odd/x odd=G.
  - 2: const_value.
  - 3: {frame_count[3:0], x[7:0]}.

Optional Feature:
Macro D8M_TX_LINE_CRC_EN.
- Defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) over each line's 12-bit pixels, MSB first, 12 bits per cycle. The CRC resets at the first pixel of each line. line_crc is updated and line_crc_valid pulses for one cycle on the cycle after lval falls. line_crc holds its value until the next line.
- Not defined: line_crc=0 and line_crc_valid=0 permanently; no CRC logic is synthesised.

Test Plan:
- Timing, params H_ACTIVE=16, V_ACTIVE=4, H_BLANK=4, FV_SETUP=2, V_BLANK=8, enable held 1 -> fval rises one edge after enable; 4 lval pulses of 16 cycles each, separated by 4 cycles; fval falls with the last lval; frame period 86 cycles; frame_done once per frame; frame_count 0->1->2.
- Pattern 1 (same params) -> line 0 = G,R alternation per bar: white FFF,FFF; yellow FFF,FFF; cyan FFF,000; green FFF,000; magenta 000,FFF; red 000,FFF; blue 000,000; black 000,000. Bar width 2 pixels. Line 1 carries B/G values.
- Pattern 2 with const_value=0xA5A; const_value changed to 0x123 mid-frame -> every active pixel in the current frame is 0xA5A; the next frame is 0x123; cam_d=0 in all blanking cycles.
- Enable dropped during line 2 -> the frame completes all 4 lines and VBLANK, then IDLE with fval=lval=0. Re-enable -> a new frame starts with x=y=0.
- reset_reset_n low for 1 cycle during ACTIVE -> next edge: fval=lval=0, cam_d=0, frame_count=0. With enable=1 after release, FSETUP starts one edge later.
- D8M_TX_LINE_CRC_EN, pattern 2, const_value=0x000 -> line_crc_valid pulses once per line, one cycle after lval falls. line_crc matches the software CRC model for 16 zero pixels, identical on all 4 lines.
